// File: rtl/regfile_nibble_writer.sv
// Writeback-stage sequencer: turns one masked 16-bit load request into
// ascending single-nibble register file writes, one quarter per cycle.
module regfile_nibble_writer #(
   parameter int DATA_W = 16,
   parameter int NIB_W  = 4,
   parameter int REG_W  = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [REG_W-1:0]  req_reg,
   input  logic [DATA_W-1:0] req_data,
   input  logic [3:0]        req_mask,
   input  logic              stall,
   output logic              write,
   output logic [REG_W-1:0]  writeReg,
   output logic [DATA_W-1:0] writeData,
   output logic [1:0]        quarter,
   output logic              busy,
   output logic              done
);

   typedef enum logic {
      IDLE,
      ISSUE
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic [REG_W-1:0]  r_lat_reg;
   logic [DATA_W-1:0] r_lat_data;
   logic [3:0]        r_pending;
   logic [3:0]        w_pending_nxt;
   logic [3:0]        w_pending_clr;
   logic [1:0]        w_cq;
   logic [NIB_W-1:0]  w_nib;
   logic              w_issue;
   logic              w_last;
   logic              w_fire;
   logic              w_finish;
   logic              w_accept;

   // Lowest set pending bit wins, so quarters always go out ascending.
   always_comb begin
      w_cq = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (r_pending[i]) w_cq = 2'(i);
      end
   end

   assign w_pending_clr = r_pending & ~(4'b0001 << w_cq);
   assign w_last        = (w_pending_clr == 4'b0000);
   assign w_nib         = r_lat_data[w_cq*NIB_W +: NIB_W];

   assign w_issue  = (r_state == ISSUE) & ~rst;
   assign w_fire   = w_issue & ~stall & (r_pending != 4'b0000);
   assign w_finish = w_issue & ~stall & w_last;
   assign w_accept = (r_state == IDLE) & req_valid;

   always_comb begin
      w_state_nxt   = r_state;
      w_pending_nxt = r_pending;
      case (r_state)
         IDLE: begin
            if (req_valid) begin
               w_state_nxt   = ISSUE;
               w_pending_nxt = req_mask;
            end
         end
         ISSUE: begin
            if (!stall) begin
               w_pending_nxt = w_pending_clr;
               if (w_last) w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pending  <= 4'b0000;
         r_lat_reg  <= '0;
         r_lat_data <= '0;
      end else begin
         r_pending <= w_pending_nxt;
         if (w_accept) begin
            r_lat_reg  <= req_reg;
            r_lat_data <= req_data;
         end
      end
   end

   // Reset gates every output so a held reset looks fully quiet.
   assign req_ready = ~rst & (r_state == IDLE);
   assign busy      = w_issue;
   assign write     = w_fire;
   assign done      = w_finish;
   assign writeReg  = rst ? '0 : r_lat_reg;
   assign quarter   = w_fire ? w_cq : 2'd0;
   assign writeData = w_fire ? {{(DATA_W-NIB_W){1'b0}}, w_nib} : '0;

endmodule

// File: doc/regfile_nibble_writer.md
# regfile_nibble_writer

Write-side sequencer for the 16-bit register file's nibble-write port. It accepts one 16-bit load request (target register, data, 4-bit quarter mask) over a valid/ready handshake. It then drives the register file's `write`/`writeReg`/`writeData`/`quarter` inputs, one masked nibble per cycle, in ascending quarter order. It sits in the writeback stage between the immediate-load decode path and the register file, so multi-nibble constants build without decode issuing four separate instructions.

## Interface
- `DATA_W`, 16, register/data width
- `NIB_W`, 4, bits written per quarter
- `REG_W`, 5, register select width (matches register file `writeReg`)
- `clk` in 1: single clock, all state updates on rising edge
- `rst` in 1: synchronous, active-high reset
- `req_valid` in 1: request present
- `req_ready` out 1: block can accept a request
- `req_reg` in REG_W: target register index
- `req_data` in DATA_W: full 16-bit value; quarter q is `req_data[4q+3:4q]`
- `req_mask` in 4: bit q set means write quarter q
- `stall` in 1: pipeline hold; suppresses writes, freezes progress
- `write` out 1: register file write enable
- `writeReg` out REG_W: register select
- `writeData` out DATA_W: `{12'b0, nibble}` when `write`=1, else 0
- `quarter` out 2: nibble position of current write
- `busy` out 1: request in progress
- `done` out 1: one-cycle pulse marking request completion

## Operation
- States: IDLE, ISSUE. State registers are `state`, `lat_reg`, `lat_data`, and `pending[3:0]`.
- IDLE:
  - `req_ready`=1, `busy`=0, `write`=0.
  - On `req_valid & req_ready`: latch `req_reg`, `req_data`, and `req_mask` into `pending`; next state is ISSUE.
- ISSUE:
  - `req_ready`=0, `busy`=1.
  - Current quarter cq = index of lowest set bit of `pending`.
- ISSUE with `stall`=0 and `pending`≠0:
  - `write`=1, `writeReg`=`lat_reg`, `quarter`=cq, `writeData[3:0]`=`lat_data[4cq+3:4cq]`.
  - Clear bit cq of `pending`.
  - If this was the last set bit: `done`=1 this cycle; next state is IDLE.
- ISSUE with `pending`=0 (request had a zero mask): `write`=0, `done`=1 (unless `stall`), next state is IDLE.
- ISSUE with `stall`=1: `write`=0, `done`=0, all registers hold. A stalled cycle never consumes a quarter.
- Output values by condition:
  - `write`=0 → `writeData`=0, `quarter`=0.
  - `writeReg` always shows `lat_reg`.
  - All outputs are combinational from registers plus `stall` only. There is no path from `req_*` to `write`.
- Cleared mask bits are skipped; nibbles are never written out of ascending order.
- Upper nibbles of `writeData` are always 0. The register file consumes only `[3:0]` for quarter writes.

## Timing
- Reset (`rst`=1 at an edge):
  - Registers: state=IDLE, `pending`=0, `lat_reg`=0, `lat_data`=0.
  - While `rst` is high, all outputs are 0, including `req_ready`; requests are ignored.
  - `req_ready`=1 in the first cycle after `rst` deasserts.
- Reset mid-ISSUE aborts the request: no further writes, no `done`.
- Latency: request accepted at edge N → first write visible in cycle N+1, registered by the register file at edge N+2.
- A request with k set mask bits and no stalls occupies k cycles of ISSUE (1 cycle if k=0). `req_ready` returns in the following cycle, giving a throughput of k+1 cycles per request.
- `done` coincides with the final `write` cycle (or the single ISSUE cycle when k=0). Each stall cycle adds exactly 1 cycle.
- `req_valid` while `req_ready`=0 is ignored; the requester must hold the request.
- `stall` is sampled every cycle. Asserting it in the final write cycle delays both `write` and `done` together.

## Test plan
- Reset then full request: reg=4, data=0xBEEF, mask=0xF, no stall.
  - Required: writes on 4 consecutive cycles, (quarter, writeData) = (0,0xF), (1,0xE), (2,0xE), (3,0xB).
  - `done` with the 4th write; `req_ready`=1 the next cycle; adr reads 0xBEEF.
- Sparse mask: reg=1, data=0x1234, mask=0b1010.
  - Required: exactly 2 writes, (1,0x3) then (3,0x1).
  - Quarters 0 and 2 of reg1 keep their prior values.
- Zero mask: reg=2, mask=0.
  - Required: `busy` 1 cycle, `done`=1 with `write`=0, `req_ready` returns 2 cycles after accept.
- Stall: mask=0xF, `stall`=1 during the 2nd and 3rd ISSUE cycles.
  - Required: `write`=0 in those cycles, quarter 1 issued after the stall, 6 ISSUE cycles total, `done` only with quarter 3.
- Reset mid-operation: mask=0xF, `rst` asserted after quarter 1 is written.
  - Required: no further writes, no `done`, outputs all 0, then `req_ready`=1.
- Back-to-back: second request held valid during the first.
  - Required: accepted only in the IDLE cycle after the first request's `done`; no writes overlap between the two requests.
